// File: rtl/rnd_backoff.sv
// rnd_backoff
//
// Randomized exponential backoff timer. Each accepted start advances the
// 3-bit pseudo-random generator once and then samples its thermometer mask.
// The mask is limited to the current exponent window, which gives the slot
// count W. The block then waits W slots of SLOT_CYC cycles each and pulses
// o_done. The exponent grows by one per backoff and saturates at MAX_EXP.
// i_clear zeroes the exponent and aborts any backoff in flight.
//
// Ports:
//   Clk          in   clock, all state on posedge
//   Reset        in   synchronous, active-high
//   i_start      in   request a backoff (only honoured in IDLE)
//   i_clear      in   transfer succeeded: zero exponent, abort backoff
//   i_rnd        in   generator value (consistency check only)
//   i_rnd_termo  in   generator thermometer mask, 2^(i_rnd+1)-1
//   o_rnd_shift  out  one-cycle advance strobe to the generator
//   o_busy       out  backoff in progress (SHIFT/SAMPLE/WAIT)
//   o_done       out  one-cycle registered expiry pulse
//   o_exp        out  current exponent
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no backoff running, waiting for i_start
// SHIFT  | strobe the generator so it produces a fresh value
// SAMPLE | capture the windowed mask as slot count, bump the exponent
// WAIT   | count slots down; each slot lasts SLOT_CYC cycles

module rnd_backoff #(
    parameter int SLOT_CYC = 16,
    parameter int TMR_W    = 5,
    parameter int MAX_EXP  = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_start,
    input  logic       i_clear,
    input  logic [2:0] i_rnd,
    input  logic [7:0] i_rnd_termo,
    output logic       o_rnd_shift,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_exp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SLOT_CYC - 1);
    localparam logic [2:0]       EXP_SAT    = 3'(MAX_EXP);

    state_t           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [7:0]       slots_q, slots_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             done_q, done_d;

    logic [7:0]       win_mask;
    logic [7:0]       slot_cnt;

    // thermo(e) = 2^(e+1)-1 as a right shift of an all-ones byte.
    assign win_mask = 8'hFF >> (3'd7 - exp_q);
    assign slot_cnt = i_rnd_termo & win_mask;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        slots_d = slots_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_clear) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                state_d = ST_SAMPLE;
            end

            ST_SAMPLE: begin
                // Window uses the exponent before this backoff's increment.
                slots_d = slot_cnt;
                tmr_d   = TMR_RELOAD;
                if (exp_q != EXP_SAT) begin
                    exp_d = exp_q + 3'd1;
                end
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (slots_q > 8'd1) begin
                    slots_d = slots_q - 8'd1;
                    tmr_d   = TMR_RELOAD;
                end else begin
                    // Last slot finished (slots<=1 also covers a zero mask,
                    // so a misbehaving generator cannot hang the block).
                    slots_d = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides everything above: exponent increment in SAMPLE
        // and a coincident expiry in WAIT both lose.
        if (i_clear) begin
            exp_d = '0;
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                slots_d = '0;
                tmr_d   = '0;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            slots_q <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            slots_q <= slots_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
        end
    end

    // The mask must match the generator value at the moment it is sampled.
    always_ff @(posedge Clk) begin
        if (!Reset && state_q == ST_SAMPLE) begin
            assert (i_rnd_termo == (8'hFF >> (3'd7 - i_rnd)));
        end
    end

    assign o_rnd_shift = (state_q == ST_SHIFT);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_exp       = exp_q;

endmodule

// File: tb/tb_rnd_backoff.sv
module tb_rnd_backoff;

    localparam int SLOT = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_clear = 1'b0;
    logic [2:0] i_rnd = 3'd0;
    logic [7:0] i_rnd_termo = 8'h01;
    logic       o_rnd_shift;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_exp;

    int checks = 0;
    int errors = 0;
    int model_e = 0;

    rnd_backoff #(.SLOT_CYC(SLOT), .TMR_W(5), .MAX_EXP(7)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_start     (i_start),
        .i_clear     (i_clear),
        .i_rnd       (i_rnd),
        .i_rnd_termo (i_rnd_termo),
        .o_rnd_shift (o_rnd_shift),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_exp       (o_exp)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit clr;
        bit chain;
        int rnd;
        int lat;
        int e_after;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the windowed mask is 2^(min(r,e)+1)-1 slots.
    function automatic int lat_of(input int r, input int e);
        int m;
        m = (r < e) ? r : e;
        return 3 + ((1 << (m + 1)) - 1) * SLOT;
    endfunction

    function automatic int exp_next(input int e);
        return (e < 7) ? e + 1 : 7;
    endfunction

    task automatic set_gen(input int r);
        int t;
        t = (1 << (r + 1)) - 1;
        i_rnd = 3'(r);
        i_rnd_termo = 8'(t);
    endtask

    // Called at a negedge with the DUT idle (or in its o_done cycle when
    // chaining). Returns at the negedge of the o_done cycle (chain) or one
    // cycle later (no chain).
    task automatic do_backoff(input string name, input int r, input int lat,
                              input int e_after, input bit chain, input int pulse_cyc);
        int cyc;
        int shifts;
        bit done_seen;
        bit busy_bad;
        i_start = 1'b1;
        @(negedge Clk);
        cyc = 1;
        i_start = 1'b0;
        chk({name, " shift@1"}, int'(o_rnd_shift), 1);
        chk({name, " busy@1"}, int'(o_busy), 1);
        shifts = o_rnd_shift ? 1 : 0;
        set_gen(r);
        done_seen = 1'b0;
        busy_bad = 1'b0;
        while (!done_seen && cyc < lat + 20) begin
            @(negedge Clk);
            cyc++;
            i_start = 1'b0;
            if (o_rnd_shift) shifts++;
            if (cyc == 2) chk({name, " exp@2"}, int'(o_exp), model_e);
            if (cyc == 3) chk({name, " exp@3"}, int'(o_exp), e_after);
            if (o_done) done_seen = 1'b1;
            else if (!o_busy) busy_bad = 1'b1;
            if (cyc == pulse_cyc) i_start = 1'b1;
        end
        chk({name, " done cycle"}, done_seen ? cyc : -1, lat);
        chk({name, " busy at done"}, int'(o_busy), 0);
        chk({name, " shift count"}, shifts, 1);
        chk({name, " busy dropout"}, int'(busy_bad), 0);
        model_e = e_after;
        if (!chain) begin
            @(negedge Clk);
            chk({name, " done width"}, int'(o_done), 0);
        end
    endtask

    task automatic clear_idle(input bit with_start);
        i_clear = 1'b1;
        i_start = with_start;
        @(negedge Clk);
        i_clear = 1'b0;
        i_start = 1'b0;
        chk("clear exp", int'(o_exp), 0);
        chk("clear busy", int'(o_busy), 0);
        chk("clear shift", int'(o_rnd_shift), 0);
        model_e = 0;
    endtask

    task automatic watch_quiet(input string name, input int n);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (o_done || o_busy || o_rnd_shift) bad = 1'b1;
        end
        chk(name, int'(bad), 0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 19, 1};
        tbl[0].rnd = 7;
        tbl[1]  = '{0, 0, 0, 19, 2};
        tbl[2]  = '{0, 0, 1, 51, 3};
        tbl[3]  = '{0, 0, 5, 243, 4};
        tbl[4]  = '{1, 0, 0, 19, 1};
        tbl[5]  = '{0, 0, 0, 19, 2};
        tbl[6]  = '{0, 0, 0, 19, 3};
        tbl[7]  = '{0, 0, 1, 51, 4};
        tbl[8]  = '{1, 1, 7, 19, 1};
        tbl[9]  = '{0, 1, 7, 51, 2};
        tbl[10] = '{0, 1, 7, 115, 3};
        tbl[11] = '{0, 1, 7, 243, 4};
        tbl[12] = '{0, 1, 7, 499, 5};
        tbl[13] = '{0, 1, 7, 1011, 6};
        tbl[14] = '{0, 1, 7, 2035, 7};
        tbl[15] = '{0, 1, 7, 4083, 7};
        tbl[16] = '{0, 0, 7, 4083, 7};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("reset idle outputs", int'({o_rnd_shift, o_busy, o_done, o_exp}), 0);
        end

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].clr) clear_idle(1'b0);
            do_backoff($sformatf("tbl%0d", i), tbl[i].rnd, tbl[i].lat,
                       tbl[i].e_after, tbl[i].chain, 0);
        end

        // Abort by i_clear in WAIT cycle 20 of a 255-slot backoff.
        begin
            i_start = 1'b1;
            @(negedge Clk);
            i_start = 1'b0;
            set_gen(7);
            for (int c = 2; c <= 20; c++) @(negedge Clk);
            chk("abort busy before clear", int'(o_busy), 1);
            i_clear = 1'b1;
            @(negedge Clk);
            i_clear = 1'b0;
            chk("abort busy", int'(o_busy), 0);
            chk("abort exp", int'(o_exp), 0);
            chk("abort done", int'(o_done), 0);
            model_e = 0;
            watch_quiet("abort quiet", 300);
        end

        clear_idle(1'b1);
        @(negedge Clk);
        chk("start+clear no shift", int'(o_rnd_shift), 0);

        do_backoff("start in wait", 7, 19, 1, 1'b0, 10);

        // Reset in WAIT.
        begin
            i_start = 1'b1;
            @(negedge Clk);
            i_start = 1'b0;
            set_gen(7);
            for (int c = 2; c <= 10; c++) @(negedge Clk);
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
            chk("reset in wait outputs", int'({o_rnd_shift, o_busy, o_done, o_exp}), 0);
            model_e = 0;
            watch_quiet("reset quiet", 100);
        end

        for (int k = 0; k < 10; k++) begin
            int r;
            int pc;
            r = int'($urandom_range(0, 7));
            pc = ($urandom_range(0, 1) == 1) ? 4 + int'($urandom_range(0, 10)) : 0;
            if ($urandom_range(0, 3) == 0) clear_idle(1'b0);
            do_backoff($sformatf("rnd%0d", k), r, lat_of(r, model_e),
                       exp_next(model_e), 1'b0, pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
